i2s_tx_sequencer: RTL
=====================

Name: i2s_tx_sequencer

Overview:
- Transmit-side controller for the audio serial interface.
- Accepts one stereo sample pair per frame through a valid/ready handshake and aligns word loads to left/right clock edges.
- Sequences MSB-first serialization on bit-clock falling edges and reports underflow.
- Sits between the audio output FIFO and the codec pins; edge-detect strobes come from the existing clock-edge generators.

Parameters:
- DATA_WIDTH, 16, sample width per channel; legal range 8..32.
- UNDERFLOW_CNT_W, 8, width of the saturating underflow counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run control; low forces IDLE.
- bit_clk_rising_edge  in  1  one-cycle strobe (unused by the datapath; reserved).
- bit_clk_falling_edge  in  1  one-cycle strobe; serial data advances here.
- lr_clk_rising_edge  in  1  one-cycle strobe; start of right channel.
- lr_clk_falling_edge  in  1  one-cycle strobe; start of frame and left channel.
- left_data  in  DATA_WIDTH  left sample.
- right_data  in  DATA_WIDTH  right sample.
- sample_valid  in  1  FIFO has a sample pair.
- sample_ready  out  1  one-cycle pop strobe.
- serial_data  out  1  codec DAC data.
- busy  out  1  high in LEFT/RIGHT.
- underflow  out  1  one-cycle pulse per starved frame.
- underflow_count  out  UNDERFLOW_CNT_W  saturating count of starved frames.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - All outputs 0.
  - Shift register, right-holding register and bits_left all 0.
- States and transitions:
  - IDLE -> SYNC when enable=1.
  - SYNC -> LEFT on lr_clk_falling_edge.
  - LEFT -> RIGHT on lr_clk_rising_edge.
  - RIGHT -> LEFT on lr_clk_falling_edge.
  - Any state -> IDLE in the cycle after enable=0 is sampled.
  - Entering IDLE clears serial_data, bits_left and both data registers; it does not clear underflow_count.
- Frame start (lr_clk_falling_edge in SYNC or RIGHT):
  - sample_valid=1: sample_ready=1 that same cycle (combinational AND of valid with the edge and state condition); left_data loads into the shift register and right_data into the hold register.
  - sample_valid=0: load zeros into both; underflow=1 for one cycle registered (next cycle); underflow_count increments, saturating at all-ones.
  - bits_left <= DATA_WIDTH.
- Right start (lr_clk_rising_edge in LEFT): hold register loads into the shift register; bits_left <= DATA_WIDTH; no handshake.
- Shift (bit_clk_falling_edge with no LR edge in the same cycle):
  - bits_left != 0: serial_data <= shift_reg[MSB]; shift left by 1 with 0 fill; bits_left decrements.
  - bits_left == 0: serial_data <= 0 (zero padding for slots wider than DATA_WIDTH).
- Latency: the MSB appears on serial_data one cycle after the first bit_clk_falling_edge strobe following the LR edge. This gives the I2S one-bit delay.
- Simultaneous events:
  - An LR edge in the same cycle as bit_clk_falling_edge: LR load wins and no shift occurs.
  - Both LR edge strobes in one cycle: protocol error; falling edge takes priority.
  - lr_clk_rising_edge in SYNC or RIGHT is ignored.
  - lr_clk_falling_edge in LEFT restarts the frame (realign): handled as a frame start with a fresh handshake.
- Short slot: if fewer than DATA_WIDTH falling edges occur before the next LR edge, the remaining bits are dropped silently.
- bits_left width = clog2(DATA_WIDTH+1).
- sample_ready is never asserted outside a frame-start cycle.

Decomposition:
- Shared package i2s_pkg holds:
  - state enum {IDLE, SYNC, LEFT, RIGHT};
  - constant MAX_DATA_WIDTH=32;
  - the clog2 helper for counter widths.
- One sub-module: tx_word_shifter. It owns the shift register, bits_left, the load/shift priority and serial_data, with ports load, load_word, shift_strobe, serial_out and done.
- The FSM, handshake and underflow logic stay in the top level.

Test Plan:
- Basic frame: DATA_WIDTH=16, left=16'hA5C3, right=16'h1234, sample_valid held high, 32 bit-clk falling edges per frame.
  - sample_ready pulses once per lr_clk_falling_edge.
  - serial_data emits 1010010111000011, then 0001001000110100, each starting one strobe after its LR edge.
- Underflow: sample_valid=0 at three consecutive frame starts.
  - serial_data all zeros; underflow pulses 3 times; underflow_count=3.
  - Preload underflow_count=255 (force via 255 starved frames); it stays at 255.
- Short and long slots:
  - 12 falling edges per slot: only the top 12 bits of 16'hFFFF are emitted, then a clean reload of the next word.
  - 24 falling edges per slot: bits 17..24 of the slot are 0.
- Collision: lr_clk_falling_edge and bit_clk_falling_edge asserted in the same cycle.
  - No bit shifts in that cycle; the first word bit is still the MSB on the next strobe.
- Enable/reset mid-word:
  - enable=0 after 5 bits of the left word: IDLE next cycle; serial_data=0; busy=0; the next enable waits in SYNC for lr_clk_falling_edge.
  - reset_n pulsed low mid-word: all outputs 0 asynchronously.
- Startup sync: enable=1 just before lr_clk_rising_edge.
  - No output and no sample_ready until the following lr_clk_falling_edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
//   state_e        : sequencer states (IDLE, SYNC, LEFT, RIGHT)
//   MAX_DATA_WIDTH : widest sample word the transmit path supports
//   clog2          : ceil(log2(value)), minimum 1, for counter widths
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_e;

  localparam int unsigned MAX_DATA_WIDTH = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v != 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tx_word_shifter.sv
// MSB-first word serializer for the I2S transmit path.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   clear         : synchronous clear of word, bit counter and serial output
//   load          : capture load_word and rearm the bit counter (beats shift)
//   load_word     : word to serialize
//   shift_strobe  : present next bit on serial_out (bit-clock falling edge)
//   serial_out    : registered serial data
//   done          : all bits of the current word have been emitted
module tx_word_shifter
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  shift_strobe,
  output logic                  serial_out,
  output logic                  done
);

  localparam int unsigned CNT_W = clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bits_left_q, bits_left_d;
  logic                  serial_q, serial_d;

  always_comb begin
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    serial_d    = serial_q;
    if (clear) begin
      shift_d     = '0;
      bits_left_d = '0;
      serial_d    = 1'b0;
    end else if (load) begin
      // serial_d holds: the new MSB only appears on the next bit strobe,
      // which yields the one-bit I2S delay after the LR edge.
      shift_d     = load_word;
      bits_left_d = CNT_W'(DATA_WIDTH);
    end else if (shift_strobe) begin
      if (bits_left_q != '0) begin
        serial_d    = shift_q[DATA_WIDTH-1];
        shift_d     = {shift_q[DATA_WIDTH-2:0], 1'b0};
        bits_left_d = bits_left_q - CNT_W'(1);
      end else begin
        // Slot wider than the word: pad with zeros.
        serial_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bits_left_q <= '0;
      serial_q    <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      serial_q    <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign done       = (bits_left_q == '0);

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: pops one stereo pair per frame from the output
// FIFO, aligns word loads to LR clock edges and serializes MSB-first on
// bit-clock falling edges. Starved frames send silence and are counted.
// Ports:
//   clk, reset_n            : system clock, asynchronous active-low reset
//   enable                  : run control; low returns to IDLE
//   bit_clk_rising_edge     : reserved strobe, not used by the datapath
//   bit_clk_falling_edge    : serial data advances on this strobe
//   lr_clk_rising_edge      : right channel start
//   lr_clk_falling_edge     : frame / left channel start
//   left_data, right_data   : sample pair offered by the FIFO
//   sample_valid            : FIFO holds a sample pair
//   sample_ready            : combinational pop strobe at frame start
//   serial_data             : DAC serial data
//   busy                    : sequencer in LEFT or RIGHT
//   underflow               : one-cycle pulse per starved frame
//   underflow_count         : saturating starved-frame count
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned UNDERFLOW_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       bit_clk_rising_edge,
  input  logic                       bit_clk_falling_edge,
  input  logic                       lr_clk_rising_edge,
  input  logic                       lr_clk_falling_edge,
  input  logic [DATA_WIDTH-1:0]      left_data,
  input  logic [DATA_WIDTH-1:0]      right_data,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       serial_data,
  output logic                       busy,
  output logic                       underflow,
  output logic [UNDERFLOW_CNT_W-1:0] underflow_count
);

  state_e                       state_q, state_d;
  logic [DATA_WIDTH-1:0]        hold_q, hold_d;
  logic                         underflow_q, underflow_d;
  logic [UNDERFLOW_CNT_W-1:0]   count_q, count_d;

  logic                         frame_start;
  logic                         right_start;
  logic                         shift_strobe;
  logic                         in_slot;
  logic                         shifter_load;
  logic [DATA_WIDTH-1:0]        shifter_word;
  logic                         word_done;
  logic                         unused_inputs;

  assign in_slot = (state_q == LEFT) || (state_q == RIGHT);

  // A falling LR edge starts a frame from SYNC, RIGHT, or LEFT (realign);
  // it also wins over a simultaneous rising edge.
  assign frame_start  = enable && lr_clk_falling_edge && (state_q != IDLE);
  assign right_start  = enable && lr_clk_rising_edge && !lr_clk_falling_edge
                        && (state_q == LEFT);
  assign shift_strobe = enable && bit_clk_falling_edge && in_slot
                        && !lr_clk_falling_edge && !lr_clk_rising_edge;

  assign shifter_load = frame_start || right_start;
  assign shifter_word = right_start  ? hold_q    :
                        sample_valid ? left_data : '0;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (lr_clk_falling_edge) state_d = LEFT;
        LEFT: begin
          if (lr_clk_falling_edge)     state_d = LEFT;
          else if (lr_clk_rising_edge) state_d = RIGHT;
        end
        RIGHT:   if (lr_clk_falling_edge) state_d = LEFT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_d      = hold_q;
    underflow_d = frame_start && !sample_valid;
    count_d     = count_q;
    if (!enable) begin
      hold_d = '0;
    end else if (frame_start) begin
      hold_d = sample_valid ? right_data : '0;
    end
    if (underflow_d && (count_q != '1)) begin
      count_d = count_q + UNDERFLOW_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      underflow_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      underflow_q <= underflow_d;
      count_q     <= count_d;
    end
  end

  tx_word_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (reset_n),
    .clear       (!enable),
    .load        (shifter_load),
    .load_word   (shifter_word),
    .shift_strobe(shift_strobe),
    .serial_out  (serial_data),
    .done        (word_done)
  );

  assign unused_inputs   = bit_clk_rising_edge ^ word_done;

  assign sample_ready    = frame_start && sample_valid;
  assign busy            = in_slot;
  assign underflow       = underflow_q;
  assign underflow_count = count_q;

endmodule
